ssd_wta_sel: RTL
================

Name: ssd_wta_sel

Overview:
- Consumer end of the PE SSD output stream. Receives the delay-aligned 20-bit SSD samples and their valid strobe.
- Per pixel, it accepts DISP_NUM consecutive valid samples. Sample k is the cost at disparity k.
- It performs winner-take-all: tracks the minimum and second-minimum SSD, then emits the winning disparity, its cost and a uniqueness flag once per pixel.
- Sits between the PE delay/alignment stage and the disparity map writer.

Parameters:
- SSD_W, 20, SSD sample width.
- DISP_NUM, 64, samples (disparities) per pixel; legal range 2..256.
- DISP_W, 6, disparity index width; must satisfy 2^DISP_W >= DISP_NUM.
- UNIQ_MARGIN, 16, minimum (second_min - min) for a match to be flagged unique.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sync_clr  input  1  discards any partial pixel; next valid sample is disparity 0.
- ssd_i  input  SSD_W  SSD sample from the PE delay stage.
- ssd_ivalid  input  1  ssd_i valid this cycle; no backpressure, every valid sample must be accepted.
- disp_o  output  DISP_W  winning disparity index.
- min_ssd_o  output  SSD_W  SSD of the winning disparity.
- unique_o  output  1  1 when (second_min - min) >= UNIQ_MARGIN.
- disp_ovalid  output  1  one-cycle pulse; disp_o, min_ssd_o and unique_o are new this cycle.

Behaviour:
- Reset:
  - rst=1 at a clock edge clears the sample counter, min_r, idx_r, disp_o, min_ssd_o, unique_o and disp_ovalid to 0.
  - sec_r is set to all-ones.
  - Reset mid-pixel discards the partial pixel; no output is produced for it.
- Sample counter cnt (0..DISP_NUM-1):
  - Increments on each accepted sample.
  - Wraps to 0 after sample DISP_NUM-1.
  - Gaps (ssd_ivalid=0) hold all state.
- State machine, two states:
  - IDLE (cnt==0) and ACC (0<cnt<DISP_NUM).
  - IDLE->ACC on a valid sample.
  - ACC->IDLE on the valid sample with cnt==DISP_NUM-1, or on sync_clr.
- Sample 0: min_r=ssd_i, idx_r=0, sec_r=all-ones.
- Sample k>0:
  - If ssd_i < min_r (strict): sec_r=min_r, min_r=ssd_i, idx_r=k.
  - Else if ssd_i < sec_r: sec_r=ssd_i.
  - Ties keep the lower disparity as winner, and the tied value becomes sec_r.
- Last sample (k=DISP_NUM-1):
  - The final compare including this sample is combinational.
  - The result is registered into disp_o, min_ssd_o and unique_o at the same edge that accepts the sample.
  - disp_ovalid=1 for exactly the following cycle.
  - Latency from last valid sample to disp_ovalid is 1 cycle.
- Uniqueness: computed as (final_sec - final_min) in SSD_W+1 bits, compared >= UNIQ_MARGIN. final_sec >= final_min always holds.
- Output hold: outputs hold between pulses. disp_ovalid is 0 in every other cycle.
- Back-to-back pixels: the next pixel's sample 0 may arrive in the cycle immediately after the last sample. No bubble is required.
- sync_clr:
  - cnt returns to 0 and the partial pixel is dropped without output.
  - If ssd_ivalid is also 1 in the same cycle, that sample is processed as sample 0 of a new pixel.
  - If sync_clr coincides with a last sample, the clear wins: no output, and the sample becomes sample 0.
- rst has priority over sync_clr and ssd_ivalid.

Test Plan:
- DISP_NUM=4, UNIQ_MARGIN=1, samples 100,50,70,50 contiguous -> one cycle after last: disp_ovalid=1, disp_o=1, min_ssd_o=50, unique_o=0 (tie, sec=50).
- DISP_NUM=4, samples 300,200,100,90 with ssd_ivalid low for 3 cycles between each -> disp_o=3, min_ssd_o=90, unique_o=0 (100-90=10<16 at default margin); disp_ovalid is a single pulse.
- Two pixels back-to-back (8 consecutive valids: 5,9,9,9 then 40,30,20,1) -> pulses on two cycles spaced 4 apart: (disp 0, min 5, unique 0 since 9-5=4<16), then (disp 3, min 1, unique 1 since 20-1=19>=16).
- sync_clr asserted with the third sample of a pixel, then 4 samples 7,8,9,10 (the sample coinciding with sync_clr counts as the 7) -> no output for the aborted pixel; one pulse with disp_o=0, min_ssd_o=7.
- All samples 20'hFFFFF -> disp_o=0, min_ssd_o=20'hFFFFF, unique_o=0.
- rst asserted after 2 of 4 samples, then 4 fresh samples 12,3,3,30 -> all outputs 0 during and after reset; exactly one pulse with disp_o=1, min_ssd_o=3.

Source files
------------

// File: rtl/ssd_wta_sel.sv
// Winner-take-all disparity selector: scans DISP_NUM SSD costs per pixel,
// keeps min and second-min, and emits the winning disparity with a uniqueness flag.
module ssd_wta_sel #(
  parameter int SSD_W       = 20,
  parameter int DISP_NUM    = 64,
  parameter int DISP_W      = 6,
  parameter int UNIQ_MARGIN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_clr,
  input  logic [SSD_W-1:0]  ssd_i,
  input  logic              ssd_ivalid,
  output logic [DISP_W-1:0] disp_o,
  output logic [SSD_W-1:0]  min_ssd_o,
  output logic              unique_o,
  output logic              disp_ovalid
);

  typedef enum logic {IDLE, ACC} state_e;

  localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(DISP_NUM - 1);
  localparam logic [SSD_W:0]    MARGIN   = (SSD_W + 1)'(UNIQ_MARGIN);

  state_e              state_q, state_d;
  logic [DISP_W-1:0]   cnt_q, cnt_d;
  logic [SSD_W-1:0]    min_q, min_d;
  logic [SSD_W-1:0]    sec_q, sec_d;
  logic [DISP_W-1:0]   idx_q, idx_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [SSD_W-1:0]    minssd_q, minssd_d;
  logic                uniq_q, uniq_d;
  logic                ovalid_q, ovalid_d;

  logic [SSD_W-1:0]    upd_min, upd_sec;
  logic [DISP_W-1:0]   upd_idx;
  logic [SSD_W:0]      upd_diff;
  logic                is_first;

  // Running min/second-min including the current sample; strict compare keeps the lower index on ties.
  always_comb begin
    upd_min = min_q;
    upd_sec = sec_q;
    upd_idx = idx_q;
    if (ssd_i < min_q) begin
      upd_sec = min_q;
      upd_min = ssd_i;
      upd_idx = cnt_q;
    end else if (ssd_i < sec_q) begin
      upd_sec = ssd_i;
    end
    upd_diff = {1'b0, upd_sec} - {1'b0, upd_min};
  end

  // A sample arriving with sync_clr starts a fresh pixel, even if it would have been the last one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    sec_d    = sec_q;
    idx_d    = idx_q;
    disp_d   = disp_q;
    minssd_d = minssd_q;
    uniq_d   = uniq_q;
    ovalid_d = 1'b0;
    is_first = sync_clr || (state_q == IDLE);

    if (ssd_ivalid) begin
      if (is_first) begin
        state_d = ACC;
        cnt_d   = DISP_W'(1);
        min_d   = ssd_i;
        sec_d   = '1;
        idx_d   = '0;
      end else begin
        min_d = upd_min;
        sec_d = upd_sec;
        idx_d = upd_idx;
        if (cnt_q == LAST_IDX) begin
          state_d  = IDLE;
          cnt_d    = '0;
          disp_d   = upd_idx;
          minssd_d = upd_min;
          uniq_d   = (upd_diff >= MARGIN);
          ovalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DISP_W'(1);
        end
      end
    end else if (sync_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      min_q    <= '0;
      sec_q    <= '1;
      idx_q    <= '0;
      disp_q   <= '0;
      minssd_q <= '0;
      uniq_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      minssd_q <= minssd_d;
      uniq_q   <= uniq_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign disp_o      = disp_q;
  assign min_ssd_o   = minssd_q;
  assign unique_o    = uniq_q;
  assign disp_ovalid = ovalid_q;

endmodule
